// File: rtl/ezdim_backlight_driver.sv
// EZDim 1-wire dimming controller: start hold, pulse bursts that step the LED driver level down (with wrap), status outputs.
// Optional feature macro EZDIM_SHUTDOWN_EN: on disable, hold the line low for T_SHDN_US before returning to OFF.
module ezdim_backlight_driver #(
  parameter int CLK_HZ     = 27000000,
  parameter int LEVEL_W    = 5,
  parameter int LEVEL_INIT = 2**LEVEL_W-1,
  parameter int T_START_US = 100,
  parameter int T_LO_US    = 10,
  parameter int T_HI_US    = 10,
  parameter int T_SHDN_US  = 3000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               level_valid,
  output logic               level_ready,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               busy,
  output logic               pulse_out
);

  localparam int DIV     = CLK_HZ / 1000000;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int T_MAX_A = (T_START_US > T_LO_US) ? T_START_US : T_LO_US;
  localparam int T_MAX_B = (T_HI_US > T_SHDN_US) ? T_HI_US : T_SHDN_US;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int PH_W    = $clog2(T_MAX + 1);

  localparam logic [PRE_W-1:0]   PRE_END   = PRE_W'(DIV - 1);
  localparam logic [PH_W-1:0]    START_END = PH_W'(T_START_US - 1);
  localparam logic [PH_W-1:0]    LO_END    = PH_W'(T_LO_US - 1);
  localparam logic [PH_W-1:0]    HI_END    = PH_W'(T_HI_US - 1);
  localparam logic [LEVEL_W-1:0] MAX_L     = '1;
  localparam logic [LEVEL_W-1:0] INIT_L    = LEVEL_W'(LEVEL_INIT);
  localparam logic [LEVEL_W-1:0] INIT_CNT  = MAX_L - INIT_L;

  typedef enum logic [2:0] {S_OFF, S_START, S_IDLE, S_LOW, S_HIGH, S_SHDN} state_t;

  state_t             state_q;
  logic [PRE_W-1:0]   pre_q;
  logic [PH_W-1:0]    ph_q;
  logic [LEVEL_W-1:0] cnt_q, target_q, cur_level_q;
  logic               pulse_q, busy_q, ready_q;

  logic               tick_d, start_done_d, lo_done_d, hi_done_d;
  logic [LEVEL_W-1:0] diff_d;

  // A phase of N us ends on the Nth tick; the prescaler restarts on every phase entry.
  assign tick_d       = (pre_q == PRE_END);
  assign start_done_d = tick_d && (ph_q == START_END);
  assign lo_done_d    = tick_d && (ph_q == LO_END);
  assign hi_done_d    = tick_d && (ph_q == HI_END);
  assign diff_d       = cur_level_q - level_in;

`ifdef EZDIM_SHUTDOWN_EN
  localparam logic [PH_W-1:0] SHDN_END = PH_W'(T_SHDN_US - 1);
  logic shdn_done_d;
  assign shdn_done_d = tick_d && (ph_q == SHDN_END);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      pre_q       <= '0;
      ph_q        <= '0;
      cnt_q       <= '0;
      target_q    <= MAX_L;
      cur_level_q <= MAX_L;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      pre_q <= tick_d ? '0 : pre_q + 1'b1;
      if (tick_d) ph_q <= ph_q + 1'b1;
`ifdef EZDIM_SHUTDOWN_EN
      if (state_q == S_SHDN) begin
        // enable is ignored here so the device always sees the full reset low-time
        if (shdn_done_d) begin
          state_q <= S_OFF;
          busy_q  <= 1'b0;
          pre_q   <= '0;
          ph_q    <= '0;
        end
      end else
`endif
      if (!enable) begin
        pulse_q     <= 1'b0;
        ready_q     <= 1'b0;
        cur_level_q <= MAX_L;
`ifdef EZDIM_SHUTDOWN_EN
        if (state_q != S_OFF) begin
          state_q <= S_SHDN;
          busy_q  <= 1'b1;
          pre_q   <= '0;
          ph_q    <= '0;
        end else begin
          busy_q <= 1'b0;
        end
`else
        busy_q  <= 1'b0;
        state_q <= S_OFF;
`endif
      end else begin
        case (state_q)
          S_OFF: begin
            state_q <= S_START;
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
            pre_q   <= '0;
            ph_q    <= '0;
          end
          S_START: begin
            if (start_done_d) begin
              cur_level_q <= MAX_L;
              target_q    <= INIT_L;
              cnt_q       <= INIT_CNT;
              pre_q       <= '0;
              ph_q        <= '0;
              if (INIT_CNT != '0) begin
                state_q <= S_LOW;
                pulse_q <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
              end
            end
          end
          S_IDLE: begin
            if (level_valid && ready_q) begin
              target_q <= level_in;
              cnt_q    <= diff_d;
              if (diff_d != '0) begin
                state_q <= S_LOW;
                pulse_q <= 1'b0;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
                pre_q   <= '0;
                ph_q    <= '0;
              end
            end
          end
          S_LOW: begin
            if (lo_done_d) begin
              cnt_q   <= cnt_q - 1'b1;
              state_q <= S_HIGH;
              pulse_q <= 1'b1;
              pre_q   <= '0;
              ph_q    <= '0;
            end
          end
          S_HIGH: begin
            if (hi_done_d) begin
              pre_q <= '0;
              ph_q  <= '0;
              if (cnt_q == '0) begin
                state_q     <= S_IDLE;
                cur_level_q <= target_q;
                busy_q      <= 1'b0;
                ready_q     <= 1'b1;
              end else begin
                state_q <= S_LOW;
                pulse_q <= 1'b0;
              end
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign level_ready = ready_q;
  assign cur_level   = cur_level_q;
  assign busy        = busy_q;
  assign pulse_out   = pulse_q;

endmodule

// File: doc/ezdim_backlight_driver.md
Name: ezdim_backlight_driver

Overview:
- Parametrised next-generation EZDim 1-wire dimming controller for constant-current LED backlight drivers.
- Generalised level width, programmable pulse and start/shutdown timing, and a valid/ready level-request handshake.
- Status outputs report the current device level and burst activity.
- Sits between the menu/brightness logic and the LED driver EN/DIM pin.

Parameters:
CLK_HZ, 27000000, system clock frequency; the 1 us prescaler divides by CLK_HZ/1000000.
LEVEL_W, 5, level width; device has 2**LEVEL_W levels, MAX = 2**LEVEL_W-1.
LEVEL_INIT, 2**LEVEL_W-1, level programmed automatically after start.
T_START_US, 100, high hold after enable before the first pulse.
T_LO_US, 10, low time of each dim pulse.
T_HI_US, 10, high time after each dim pulse.
T_SHDN_US, 3000, low hold for device shutdown (optional feature only).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = driver on; 0 = line low / shutdown
level_in  in  LEVEL_W  requested level
level_valid  in  1  request strobe
level_ready  out  1  request accepted when valid&ready
cur_level  out  LEVEL_W  level the device currently holds
busy  out  1  start hold or pulse burst in progress
pulse_out  out  1  EZDim line to LED driver

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - pulse_out=0, level_ready=0, busy=0, cur_level=MAX.
  - Prescaler and phase counter cleared; state OFF.
- Timebase:
  - Prescaler emits a 1-cycle tick every CLK_HZ/1000000 clocks.
  - A phase of N us ends on the clock edge of the Nth tick after phase entry.
- States:
  - OFF: pulse_out=0. enable=1 -> START (pulse_out=1 on the same edge, busy=1).
  - START: hold high T_START_US. Then cur_level=MAX, pulse count = MAX-LEVEL_INIT (LEVEL_W-bit).
    - Count nonzero -> LOW; count zero -> IDLE.
  - IDLE: pulse_out=1, busy=0, level_ready=1.
    - On valid&ready: count = (cur_level - level_in) mod 2**LEVEL_W, target latched.
    - Count 0 -> stay IDLE (no pulses, ready stays 1). Otherwise -> LOW, ready=0, busy=1.
  - LOW: pulse_out=0 for T_LO_US, count decremented, -> HIGH.
  - HIGH: pulse_out=1 for T_HI_US.
    - Count zero -> IDLE and cur_level=target on the same edge. Otherwise -> LOW.
- Wrap-around: each pulse lowers the device level by one, and level 0 wraps to MAX.
  - Raising the level therefore uses the modulo count; e.g. LEVEL_W=5, 10->12 = 30 pulses.
- level_ready is only 1 in IDLE with enable=1. Requests while busy are not accepted; the requester holds valid.
- level_in is sampled only at the handshake. Later changes have no effect until the next handshake.
- enable=0 in any state (checked every clock, highest priority):
  - pulse_out=0, level_ready=0, busy=0; the burst is abandoned.
  - cur_level=MAX (device state unknown; it re-inits on next start); next state per optional feature.
- Simultaneous enable fall and valid&ready: the disable wins and the request is dropped.
- Phase counter width = $clog2(max of T_* + 1). Level subtraction is LEVEL_W-bit unsigned, dropping the borrow.

Optional Feature:
- Macro: EZDIM_SHUTDOWN_EN.
- Defined:
  - enable=0 enters SHDN: pulse_out=0 and busy=1 for T_SHDN_US, then OFF.
  - enable returning to 1 during SHDN is ignored until SHDN completes. This guarantees the device reset low-time.
- Undefined:
  - enable=0 goes straight to OFF on the next edge.
  - Restart is possible after one tick in OFF. The user guarantees the low time externally.

Test Plan:
- CLK_HZ=4000000, LEVEL_W=5, LEVEL_INIT=31, T_LO_US=T_HI_US=10, T_START_US=100:
  - Release rst_n, enable=1 -> pulse_out high 100 us, no pulses, level_ready=1, cur_level=31, busy 100 us.
- From 31, request 28 -> exactly 3 low pulses, each 40 clocks low / 40 high.
  - cur_level=28 on the final HIGH-end edge; ready=0 throughout the burst.
- From 10, request 12 -> 30 pulses (wrap path), cur_level=12. Request equal to cur_level -> zero pulses, ready stays 1.
- Hold level_valid with new level 5 mid-burst -> no acceptance until IDLE, then 23 pulses from 28.
  - Changing level_in mid-burst does not alter the count.
- Drop enable during the 2nd LOW of a burst -> pulse_out=0 next edge, cur_level=31, ready=0.
  - With EZDIM_SHUTDOWN_EN: busy held 3000 us and re-enable ignored until done. Without it: OFF immediately.
- Assert rst_n low mid-HIGH phase, asynchronously off-edge -> pulse_out/busy/ready 0 immediately, cur_level=31.
  - After release: no activity until enable sampled high.
